fetch_pc_stage: RTL and testbench

Instruction-fetch PC generator sitting directly upstream of the 2-bit branch predictor. Each cycle it drives the current fetch PC onto the predictor's `pc` input and combines the returned `prediction` with an internal direct-mapped branch target buffer (BTB) to pick the next PC. It forwards fetched PCs to decode over a valid/ready register slice. On branch resolution from execute it time-shares the predictor's PC port to perform the table update, and redirects fetch on mispredict.

---
 rtl/fetch_pc_stage_pkg.sv | 36 +++
 rtl/fetch_pc_stage_btb_dm.sv | 45 ++++
 rtl/fetch_pc_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_pc_stage.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_stage_pkg.sv
// Shared widths and types for the fetch PC stage, its BTB and the downstream predictor.
package fetch_pc_stage_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned INSN_BYTES  = 4;
    localparam int unsigned OFF_BITS    = 2;
    localparam int unsigned BP_IDX_BITS = 4;
    localparam int unsigned BTB_TAG_W   = PC_W - BP_IDX_BITS - OFF_BITS;
    localparam int unsigned BTB_TGT_W   = PC_W - OFF_BITS;
    localparam int unsigned CNT_W       = 16;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_TGT_W-1:0] target;
    } btb_entry_t;

    // Per-cycle action of the fetch stage, in priority order (reset handled separately).
    typedef enum logic [1:0] {
        ACT_HOLD     = 2'd0,
        ACT_ADVANCE  = 2'd1,
        ACT_UPDATE   = 2'd2,
        ACT_REDIRECT = 2'd3
    } fetch_act_e;

    // Word-aligned sequential successor, wrapping modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_next_seq(input logic [PC_W-1:0] pc);
        return (pc & ~PC_W'(INSN_BYTES - 1)) + PC_W'(INSN_BYTES);
    endfunction

    // Clears the byte-offset bits of an address.
    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(INSN_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_pc_stage_btb_dm.sv
// Direct-mapped branch target buffer: one combinational read port, one write port,
// valid bits cleared by synchronous reset.
module btb_dm
    import fetch_pc_stage_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned IDX_BITS = BP_IDX_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_BITS-1:0]  rd_idx_i,
    output btb_entry_t           rd_entry_c_o,
    input  logic                 wr_en_i,
    input  logic [IDX_BITS-1:0]  wr_idx_i,
    input  logic [BTB_TAG_W-1:0] wr_tag_i,
    input  logic [BTB_TGT_W-1:0] wr_target_i
);

    logic [ENTRIES-1:0]   valid_q;
    logic [BTB_TAG_W-1:0] tag_q    [ENTRIES];
    logic [BTB_TGT_W-1:0] target_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag/target storage needs no reset; an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

    always_comb begin
        rd_entry_c_o.valid  = valid_q[rd_idx_i];
        rd_entry_c_o.tag    = tag_q[rd_idx_i];
        rd_entry_c_o.target = target_q[rd_idx_i];
    end

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch PC generator: drives the branch predictor, picks the next PC, feeds decode
// through a valid/ready slice. BTB present only when FETCH_BTB_EN is defined.
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned     BTB_ENTRIES  = 16,
    parameter int unsigned     BTB_IDX_BITS = BP_IDX_BITS
) (
    input  logic             clk,
    input  logic             rst,
    output logic [PC_W-1:0]  bp_pc,
    output logic             bp_branch,
    output logic             bp_taken,
    input  logic             bp_prediction,
    output logic             f_valid,
    input  logic             f_ready,
    output logic [PC_W-1:0]  f_pc,
    output logic             f_pred_taken,
    output logic [PC_W-1:0]  f_pred_target,
    input  logic             res_valid,
    input  logic [PC_W-1:0]  res_pc,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_target,
    input  logic             res_mispredict,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int unsigned IDX_LO = OFF_BITS;
    localparam int unsigned IDX_HI = BTB_IDX_BITS + OFF_BITS - 1;
    localparam int unsigned TAG_LO = BTB_IDX_BITS + OFF_BITS;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             f_valid_q, f_valid_d;
    logic [PC_W-1:0]  f_pc_q, f_pc_d;
    logic             f_pred_taken_q, f_pred_taken_d;
    logic [PC_W-1:0]  f_pred_target_q, f_pred_target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    fetch_act_e       act_c;
    logic             btb_hit_c;
    logic [PC_W-1:0]  btb_target_c;
    logic             pred_taken_c;
    logic [PC_W-1:0]  pred_next_c;
    logic [PC_W-1:0]  redirect_pc_c;

    // Resolve traffic borrows the predictor PC port for its table update.
    assign bp_pc     = res_valid ? res_pc : pc_q;
    assign bp_branch = res_valid;
    assign bp_taken  = res_taken;

`ifdef FETCH_BTB_EN
    btb_entry_t btb_rd_c;

    btb_dm #(
        .ENTRIES  (BTB_ENTRIES),
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .rd_idx_i     (pc_q[IDX_HI:IDX_LO]),
        .rd_entry_c_o (btb_rd_c),
        .wr_en_i      (res_valid & res_taken),
        .wr_idx_i     (res_pc[IDX_HI:IDX_LO]),
        .wr_tag_i     (res_pc[PC_W-1:TAG_LO]),
        .wr_target_i  (res_target[PC_W-1:OFF_BITS])
    );

    assign btb_hit_c    = btb_rd_c.valid && (btb_rd_c.tag == pc_q[PC_W-1:TAG_LO]);
    assign btb_target_c = {btb_rd_c.target, {OFF_BITS{1'b0}}};
`else
    assign btb_hit_c    = 1'b0;
    assign btb_target_c = '0;
`endif

    assign pred_taken_c  = btb_hit_c & bp_prediction;
    assign pred_next_c   = pred_taken_c ? btb_target_c : pc_next_seq(pc_q);
    assign redirect_pc_c = res_taken ? pc_align(res_target) : pc_next_seq(res_pc);

    // Action select: redirect > update slot > advance > hold.
    always_comb begin
        act_c = ACT_HOLD;
        if (res_valid && res_mispredict) begin
            act_c = ACT_REDIRECT;
        end else if (res_valid) begin
            act_c = ACT_UPDATE;
        end else if (!f_valid_q || f_ready) begin
            act_c = ACT_ADVANCE;
        end
    end

    always_comb begin
        pc_d            = pc_q;
        f_valid_d       = f_valid_q;
        f_pc_d          = f_pc_q;
        f_pred_taken_d  = f_pred_taken_q;
        f_pred_target_d = f_pred_target_q;
        cnt_d           = cnt_q;
        unique case (act_c)
            ACT_REDIRECT: begin
                pc_d      = redirect_pc_c;
                f_valid_d = 1'b0;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACT_ADVANCE: begin
                pc_d            = pred_next_c;
                f_valid_d       = 1'b1;
                f_pc_d          = pc_q;
                f_pred_taken_d  = pred_taken_c;
                f_pred_target_d = pred_next_c;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= pc_align(RESET_PC);
            f_valid_q       <= 1'b0;
            f_pc_q          <= '0;
            f_pred_taken_q  <= 1'b0;
            f_pred_target_q <= '0;
            cnt_q           <= '0;
        end else begin
            pc_q            <= pc_d;
            f_valid_q       <= f_valid_d;
            f_pc_q          <= f_pc_d;
            f_pred_taken_q  <= f_pred_taken_d;
            f_pred_target_q <= f_pred_target_d;
            cnt_q           <= cnt_d;
        end
    end

    assign f_valid        = f_valid_q;
    assign f_pc           = f_pc_q;
    assign f_pred_taken   = f_pred_taken_q;
    assign f_pred_target  = f_pred_target_q;
    assign redirect_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage; expectations follow FETCH_BTB_EN if defined.
module tb_fetch_pc_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bp_pc;
    logic        bp_branch;
    logic        bp_taken;
    logic        bp_prediction;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_mispredict;
    logic [15:0] redirect_count;

    fetch_pc_stage #(
        .RESET_PC     (RST_PC),
        .BTB_ENTRIES  (16),
        .BTB_IDX_BITS (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bp_pc          (bp_pc),
        .bp_branch      (bp_branch),
        .bp_taken       (bp_taken),
        .bp_prediction  (bp_prediction),
        .f_valid        (f_valid),
        .f_ready        (f_ready),
        .f_pc           (f_pc),
        .f_pred_taken   (f_pred_taken),
        .f_pred_target  (f_pred_target),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .res_mispredict (res_mispredict),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc  = '0;
    logic        m_v   = 1'b0;
    logic [31:0] m_fpc = '0;
    logic        m_pt  = 1'b0;
    logic [31:0] m_tgt = '0;
    logic [15:0] m_cnt = '0;
`ifdef FETCH_BTB_EN
    logic        m_bv   [16];
    logic [25:0] m_btag [16];
    logic [31:0] m_btgt [16];
`endif

    task automatic model_step();
        logic        taken;
        logic [31:0] nxt;
        int          idx;
        taken = 1'b0;
        idx   = 0;
        if (rst) begin
            m_pc  = RST_PC;
            m_v   = 1'b0;
            m_fpc = '0;
            m_pt  = 1'b0;
            m_tgt = '0;
            m_cnt = '0;
`ifdef FETCH_BTB_EN
            for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
`endif
        end else if (res_valid) begin
            if (res_mispredict) begin
                m_pc = res_taken ? {res_target[31:2], 2'b00} : res_pc + 32'd4;
                m_v  = 1'b0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
`ifdef FETCH_BTB_EN
            if (res_taken) begin
                idx         = int'(res_pc[5:2]);
                m_bv[idx]   = 1'b1;
                m_btag[idx] = res_pc[31:6];
                m_btgt[idx] = {res_target[31:2], 2'b00};
            end
`endif
        end else if (!m_v || f_ready) begin
            nxt = m_pc + 32'd4;
`ifdef FETCH_BTB_EN
            idx = int'(m_pc[5:2]);
            if (m_bv[idx] && m_btag[idx] == m_pc[31:6] && bp_prediction) begin
                taken = 1'b1;
                nxt   = m_btgt[idx];
            end
`endif
            m_v   = 1'b1;
            m_fpc = m_pc;
            m_pt  = taken;
            m_tgt = nxt;
            m_pc  = nxt;
        end
    endtask

    // One clock: model the edge, queue the expectation, then check the DUT after the edge.
    task automatic cycle();
        exp_t e;
        logic bad;
        model_step();
        sb_q.push_back('{v: m_v, pc: m_fpc, pt: m_pt, tgt: m_tgt, cnt: m_cnt});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_tests++;
        if (e.v) bad = ({f_valid, f_pc, f_pred_taken, f_pred_target, redirect_count} !== e);
        else     bad = (f_valid !== 1'b0) || (redirect_count !== e.cnt);
        if (bad) begin
            n_fail++;
            $display("FAIL sb_cycle t=%0t got v=%b pc=%h pt=%b tgt=%h cnt=%h want v=%b pc=%h pt=%b tgt=%h cnt=%h",
                     $time, f_valid, f_pc, f_pred_taken, f_pred_target, redirect_count,
                     e.v, e.pc, e.pt, e.tgt, e.cnt);
        end
        #2;
    endtask

    task automatic set_res(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic mp);
        res_valid      = v;
        res_pc         = pc;
        res_taken      = tk;
        res_target     = tgt;
        res_mispredict = mp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        f_ready = 1'b1;
        bp_prediction = 1'b0;
        set_res(1'b0, '0, 1'b0, '0, 1'b0);
        #1; cycle();
        #1; cycle();
        n_tests++;
        if ({f_valid, f_pc, f_pred_taken, f_pred_target, redirect_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b pc=%h pt=%b tgt=%h cnt=%h want all zero",
                     f_valid, f_pc, f_pred_taken, f_pred_target, redirect_count);
        end
        n_tests++;
        if (bp_pc !== RST_PC || bp_branch !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bp got bp_pc=%h branch=%b want %h 0", bp_pc, bp_branch, RST_PC);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        bp_prediction = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; cycle();
            n_tests++;
            if (f_valid !== 1'b1 || f_pc !== RST_PC + 32'(4 * i) || f_pred_taken !== 1'b0 ||
                f_pred_target !== RST_PC + 32'(4 * (i + 1))) begin
                n_fail++;
                $display("FAIL seq_%0d got v=%b pc=%h pt=%b tgt=%h want 1 %h 0 %h", i, f_valid, f_pc,
                         f_pred_taken, f_pred_target, RST_PC + 32'(4 * i), RST_PC + 32'(4 * (i + 1)));
            end
        end
        bp_prediction = 1'b0;
    endtask

    task automatic test_redirect();
        set_res(1'b1, 32'h108, 1'b1, 32'h200, 1'b1);
        #1;
        n_tests++;
        if (bp_branch !== 1'b1 || bp_pc !== 32'h108 || bp_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_bp got br=%b pc=%h tk=%b want 1 00000108 1", bp_branch, bp_pc, bp_taken);
        end
        cycle();
        n_tests++;
        if (f_valid !== 1'b0 || redirect_count !== 16'd1) begin
            n_fail++;
            $display("FAIL redirect_flush got v=%b cnt=%0d want 0 1", f_valid, redirect_count);
        end
        set_res(1'b0, '0, 1'b0, '0, 1'b0);
        #1; cycle();
        n_tests++;
        if (f_valid !== 1'b1 || f_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL redirect_target got v=%b pc=%h want 1 00000200", f_valid, f_pc);
        end
    endtask

    task automatic test_btb_predict();
        logic        exp_pt;
        logic [31:0] exp_tgt;
`ifdef FETCH_BTB_EN
        exp_pt = 1'b1; exp_tgt = 32'h200;
`else
        exp_pt = 1'b0; exp_tgt = 32'h10C;
`endif
        set_res(1'b1, 32'h104, 1'b0, 32'h0, 1'b1);
        #1; cycle();
        set_res(1'b0, '0, 1'b0, '0, 1'b0);
        bp_prediction = 1'b1;
        #1; cycle();
        n_tests++;
        if (f_pc !== 32'h108 || f_pred_taken !== exp_pt || f_pred_target !== exp_tgt) begin
            n_fail++;
            $display("FAIL btb_pred got pc=%h pt=%b tgt=%h want 00000108 %b %h",
                     f_pc, f_pred_taken, f_pred_target, exp_pt, exp_tgt);
        end
        bp_prediction = 1'b0;
        #1; cycle();
        n_tests++;
        if (f_pc !== exp_tgt) begin
            n_fail++;
            $display("FAIL btb_follow got pc=%h want %h", f_pc, exp_tgt);
        end
    endtask

    task automatic test_stall();
        logic [31:0] x;
`ifdef FETCH_BTB_EN
        x = 32'h200;
`else
        x = 32'h10C;
`endif
        f_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; cycle();
            n_tests++;
            if (f_valid !== 1'b1 || f_pc !== x) begin
                n_fail++;
                $display("FAIL stall_%0d got v=%b pc=%h want 1 %h", i, f_valid, f_pc, x);
            end
        end
        f_ready = 1'b1;
        #1; cycle();
        n_tests++;
        if (f_valid !== 1'b1 || f_pc !== x + 32'd4) begin
            n_fail++;
            $display("FAIL stall_resume got v=%b pc=%h want 1 %h", f_valid, f_pc, x + 32'd4);
        end
    endtask

    task automatic test_redirect_stall();
        f_ready = 1'b0;
        #1; cycle();
        set_res(1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        #1; cycle();
        n_tests++;
        if (f_valid !== 1'b0 || redirect_count !== 16'd3) begin
            n_fail++;
            $display("FAIL redir_stall_flush got v=%b cnt=%0d want 0 3", f_valid, redirect_count);
        end
        set_res(1'b0, '0, 1'b0, '0, 1'b0);
        #1; cycle();
        n_tests++;
        if (f_valid !== 1'b1 || f_pc !== 32'h304) begin
            n_fail++;
            $display("FAIL redir_stall_refill got v=%b pc=%h want 1 00000304", f_valid, f_pc);
        end
        #1; cycle();
        f_ready = 1'b1;
    endtask

    task automatic test_update_bubble();
        set_res(1'b1, 32'h500, 1'b1, 32'h600, 1'b0);
        #1; cycle();
        set_res(1'b0, '0, 1'b0, '0, 1'b0);
        #1; cycle();
        n_tests++;
        if (f_valid !== 1'b1 || f_pc !== 32'h308 || redirect_count !== 16'd3) begin
            n_fail++;
            $display("FAIL update_bubble got v=%b pc=%h cnt=%0d want 1 00000308 3", f_valid, f_pc, redirect_count);
        end
    endtask

    task automatic test_wrap();
        set_res(1'b1, 32'h400, 1'b1, 32'hFFFF_FFFF, 1'b1);
        #1; cycle();
        set_res(1'b0, '0, 1'b0, '0, 1'b0);
        #1; cycle();
        n_tests++;
        if (f_pc !== 32'hFFFF_FFFC || f_pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_top got pc=%h tgt=%h want fffffffc 00000000", f_pc, f_pred_target);
        end
        set_res(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
        #1; cycle();
        set_res(1'b0, '0, 1'b0, '0, 1'b0);
        #1; cycle();
        n_tests++;
        if (f_valid !== 1'b1 || f_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_zero got v=%b pc=%h want 1 00000000", f_valid, f_pc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            f_ready       = ($urandom_range(0, 3) != 0);
            bp_prediction = $urandom_range(0, 1) == 1;
            set_res($urandom_range(0, 3) == 0, 32'($urandom_range(0, 127)) << 2,
                    $urandom_range(0, 1) == 1,
                    (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1);
            #1;
            n_tests++;
            if (bp_pc !== (res_valid ? res_pc : m_pc) || bp_branch !== res_valid || bp_taken !== res_taken) begin
                n_fail++;
                $display("FAIL rand_bp_%0d got pc=%h br=%b tk=%b want %h %b %b", i, bp_pc, bp_branch,
                         bp_taken, res_valid ? res_pc : m_pc, res_valid, res_taken);
            end
            cycle();
`ifndef FETCH_BTB_EN
            n_tests++;
            if (f_pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_nobtb_%0d got pt=%b want 0", i, f_pred_taken);
            end
`endif
        end
        rst = 1'b0;
        f_ready = 1'b1;
        set_res(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_saturate();
        set_res(1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 65540; i++) begin
            #1; cycle();
        end
        n_tests++;
        if (redirect_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturate got cnt=%h want ffff", redirect_count);
        end
        set_res(1'b0, '0, 1'b0, '0, 1'b0);
        #1; cycle();
        n_tests++;
        if (f_valid !== 1'b1 || f_pc !== 32'h44 || redirect_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturate_resume got v=%b pc=%h cnt=%h want 1 00000044 ffff", f_valid, f_pc, redirect_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        f_ready = 1'b1;
        bp_prediction = 1'b0;
        set_res(1'b0, '0, 1'b0, '0, 1'b0);
        #2;
        test_reset();
        test_sequential();
        test_redirect();
        test_btb_predict();
        test_stall();
        test_redirect_stall();
        test_update_bubble();
        test_wrap();
        test_random();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
